// File: rtl/argmax_stream.sv
// argmax_stream
//   Streaming argmax over one frame of signed class scores, one score per
//   valid/ready beat. When a frame closes, the winning index and score are
//   presented until the consumer takes them. Ties go to the lowest index.
//   A frame whose length differs from NUM_CLASSES is flagged with out_err.
//
//   Optional build macro ARGMAX_TOP2_EN adds runner-up index/score and the
//   margin between the winner and the runner-up.
//
// Ports
//   clk         single clock, posedge
//   rst         synchronous, active-high reset
//   in_valid    score beat valid
//   in_ready    block can accept a beat
//   in_data     signed score
//   in_last     final beat of a frame
//   out_valid   result valid, held until out_ready
//   out_ready   consumer accepts result
//   out_index   index of the maximum score
//   out_value   maximum score
//   out_err     frame length != NUM_CLASSES
//   out_index2  (ARGMAX_TOP2_EN) index of the runner-up score
//   out_value2  (ARGMAX_TOP2_EN) runner-up score
//   out_margin  (ARGMAX_TOP2_EN) out_value - out_value2, DATA_W+1 bits signed
//
// States
//   ACCUM | accepting beats, tracking the running maximum
//   HOLD  | result presented, waiting for out_ready
module argmax_stream #(
    parameter int DATA_W      = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_value,
    output logic              out_err
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [IDX_W-1:0]  out_index2,
    output logic [DATA_W-1:0] out_value2,
    output logic [DATA_W:0]   out_margin
`endif
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(NUM_CLASSES - 1);

    state_t            state, state_next;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] best;
    logic [IDX_W-1:0]  idx;
    logic              err;

    logic accept, at_last_pos, frame_end, first_beat, gt_best;

    // Accept is derived from the state directly rather than from in_ready so
    // the FSM output process does not feed back into itself.
    assign accept      = in_valid && (state == ACCUM);
    assign at_last_pos = (cnt == LAST_POS);
    assign frame_end   = accept && (in_last || at_last_pos);
    assign first_beat  = (cnt == '0);
    assign gt_best     = $signed(in_data) > $signed(best);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (frame_end) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            best <= '0;
            idx  <= '0;
            err  <= 1'b0;
        end else if (accept) begin
            if (first_beat) begin
                best <= in_data;
                idx  <= '0;
            end else if (gt_best) begin
                best <= in_data;
                idx  <= cnt;
            end
            if (frame_end) begin
                cnt <= '0;
                // Error when in_last and the nominal last position disagree:
                // early in_last (short) or missing in_last (long).
                err <= (in_last != at_last_pos);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out_index = idx;
    assign out_value = best;
    assign out_err   = err;

`ifdef ARGMAX_TOP2_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] second;
    logic [IDX_W-1:0]  idx2;
    logic              gt_second;

    assign gt_second = $signed(in_data) > $signed(second);

    always_ff @(posedge clk) begin
        if (rst) begin
            second <= '0;
            idx2   <= '0;
        end else if (accept) begin
            if (first_beat) begin
                // Single-beat frames report the most negative score as runner-up.
                second <= MOST_NEG;
                idx2   <= '0;
            end else if (gt_best) begin
                second <= best;
                idx2   <= idx;
            end else if ((cnt == IDX_W'(1)) || gt_second) begin
                // The second beat always displaces the initial most-negative runner-up.
                second <= in_data;
                idx2   <= cnt;
            end
        end
    end

    assign out_index2 = idx2;
    assign out_value2 = second;
    assign out_margin = $signed({best[DATA_W-1], best}) - $signed({second[DATA_W-1], second});
`endif

endmodule

// File: tb/tb_argmax_stream.sv
module tb_argmax_stream;
    localparam int DW = 32;
    localparam int NC = 10;
    localparam int IW = $clog2(NC);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [DW-1:0] out_value;
    logic          out_err;
`ifdef ARGMAX_TOP2_EN
    logic [IW-1:0] out_index2;
    logic [DW-1:0] out_value2;
    logic [DW:0]   out_margin;
`endif

    argmax_stream #(.DATA_W(DW), .NUM_CLASSES(NC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_value(out_value), .out_err(out_err)
`ifdef ARGMAX_TOP2_EN
        , .out_index2(out_index2), .out_value2(out_value2), .out_margin(out_margin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
        logic          err;
        logic [IW-1:0] idx2;
        logic [DW-1:0] val2;
    } res_t;

    res_t exp_q[$];
    int   scores_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first maximum over the frame; runner-up is the first maximum
    // over all other positions (most-negative value for 1-beat frames).
    task automatic push_expected(input int n, input bit last);
        res_t r;
        bit   found;
        r.idx = '0;
        r.val = scores_q[0];
        for (int i = 1; i < n; i++)
            if (scores_q[i] > $signed(r.val)) begin
                r.val = scores_q[i];
                r.idx = IW'(i);
            end
        r.err  = (last != (n == NC));
        r.val2 = 32'h8000_0000;
        r.idx2 = '0;
        found  = 1'b0;
        for (int i = 0; i < n; i++)
            if (i != int'(r.idx) && (!found || scores_q[i] > $signed(r.val2))) begin
                found  = 1'b1;
                r.val2 = scores_q[i];
                r.idx2 = IW'(i);
            end
        exp_q.push_back(r);
    endtask

    task automatic send_beat(input logic [DW-1:0] data, input logic last);
        int budget = 20;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit last);
        for (int i = 0; i < n; i++) send_beat(scores_q[i], last && (i == n - 1));
        push_expected(n, last);
        check("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic expect_result(input string tag);
        res_t r;
        int   budget = 50;
        while (!out_valid && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!out_valid) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            r = exp_q.pop_front();
            check({tag, "_index"}, 64'(out_index), 64'(r.idx));
            check({tag, "_value"}, 64'(out_value), 64'(r.val));
            check({tag, "_err"},   64'(out_err),   64'(r.err));
`ifdef ARGMAX_TOP2_EN
            check({tag, "_index2"}, 64'(out_index2), 64'(r.idx2));
            check({tag, "_value2"}, 64'(out_value2), 64'(r.val2));
            check({tag, "_margin"}, 64'(out_margin),
                  64'(33'($signed({r.val[DW-1], r.val}) - $signed({r.val2[DW-1], r.val2}))));
`endif
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_index", 64'(out_index), 64'd0);
        check("reset_out_value", 64'(out_value), 64'd0);
        check("reset_out_err",   64'(out_err),   64'd0);
`ifdef ARGMAX_TOP2_EN
        check("reset_out_value2", 64'(out_value2), 64'd0);
        check("reset_out_margin", 64'(out_margin), 64'd0);
`endif

        // Tie resolves to the lower index; expected index 2, value 9.
        scores_q = '{5, -3, 9, 2, 9, 0, 1, -7, 8, 4};
        send_frame(10, 1'b1);
        expect_result("t1_tie");

        // All most-negative scores: index 0, value -2^31.
        scores_q = {};
        for (int i = 0; i < NC; i++) scores_q.push_back(int'(32'h8000_0000));
        send_frame(10, 1'b1);
        expect_result("t2_minval");

        // Short frame then a full ascending frame.
        scores_q = '{1, 7, 3, 2};
        send_frame(4, 1'b1);
        expect_result("t3_short");
        scores_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_frame(10, 1'b1);
        expect_result("t3_full");

        // Long frame: closes at beat 9 with err; beat 10 opens a new frame.
        scores_q = '{-10, 20, -30, 40, 39, -60, 40, 0, 1, 2};
        send_frame(10, 1'b0);
        expect_result("t4_long");
        scores_q = '{100};
        send_frame(1, 1'b1);
        expect_result("t4_next");

        // Back-pressure: result held stable with in_ready low.
        scores_q = '{-8, -5, -2, -9, -3, -2, -100, -4, -6, -7};
        send_frame(10, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_out_valid", 64'(out_valid), 64'd1);
            check("t5_hold_in_ready",  64'(in_ready),  64'd0);
            check("t5_hold_index",     64'(out_index), 64'(exp_q[0].idx));
            check("t5_hold_value",     64'(out_value), 64'(exp_q[0].val));
            @(posedge clk); #1;
        end
        expect_result("t5_bp");

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++) send_beat(32'd1000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_in_ready",  64'(in_ready),  64'd1);
        check("t6_out_value", 64'(out_value), 64'd0);
        scores_q = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        send_frame(10, 1'b1);
        expect_result("t6_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
